// File: rtl/layer_sequencer_pkg.sv
// Shared types and constants for the layer sequencer and its descriptor table.
// Field indices match the low three bits of cfg_addr.
package layer_sequencer_pkg;

  localparam int PE_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ENABLE,
    S_CFG,
    S_RUN,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [2:0] FLD_IN   = 3'd0;
  localparam logic [2:0] FLD_WGT  = 3'd1;
  localparam logic [2:0] FLD_OUT  = 3'd2;
  localparam logic [2:0] FLD_NIN  = 3'd3;
  localparam logic [2:0] FLD_NOUT = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DESC = 2'd1;
  localparam logic [1:0] ERR_WDOG = 2'd2;

endpackage

// File: rtl/layer_desc_table.sv
// Per-layer descriptor storage: one write port, one combinational read port.
// rd_ok flags whether the addressed layer holds a runnable descriptor.
module layer_desc_table
  import layer_sequencer_pkg::*;
#(
  parameter int MAX_LAYERS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [2:0]          wr_layer,
  input  logic [2:0]          wr_field,
  input  logic [PE_WIDTH-1:0] wdata,
  input  logic [2:0]          rd_layer,
  input  logic [2:0]          rd_field,
  output logic [PE_WIDTH-1:0] rd_data,
  output logic                rd_ok
);

  logic [PE_WIDTH-1:0] mem [MAX_LAYERS][5];
  logic [PE_WIDTH-1:0] n_in;
  logic [PE_WIDTH-1:0] n_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < MAX_LAYERS; l++) begin
        for (int f = 0; f < 5; f++) begin
          mem[l][f] <= '0;
        end
      end
    end else if (we && (wr_field <= FLD_NOUT) && (int'(wr_layer) < MAX_LAYERS)) begin
      mem[wr_layer][wr_field] <= wdata;
    end
  end

  // n_in must be a non-zero multiple of 16 and n_out non-zero
  always_comb begin
    rd_data = '0;
    n_in    = '0;
    n_out   = '0;
    if (int'(rd_layer) < MAX_LAYERS) begin
      n_in  = mem[rd_layer][FLD_NIN];
      n_out = mem[rd_layer][FLD_NOUT];
      if (rd_field <= FLD_NOUT) begin
        rd_data = mem[rd_layer][rd_field];
      end
    end
    rd_ok = (n_in != '0) && (n_in[3:0] == 4'd0) && (n_out != '0);
  end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the descriptor table layer by layer: validate, enable, stream five
// config words, then wait for n_out neuron completions under a watchdog.
//
// state    | meaning
// IDLE     | waiting for start
// CHECK    | validate current layer descriptor
// ENABLE   | one-cycle accel_enable pulse
// CFG      | five config beats on accel_databus
// RUN      | counting neuron_done, watchdog armed
// NEXT     | advance layer or finish
// FINISH   | done pulse, back to IDLE
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int WDOG_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [PE_WIDTH-1:0] cfg_wdata,
  input  logic [3:0]          num_layers,
  input  logic                start,
  input  logic                neuron_done,
  output logic                accel_enable,
  output logic [PE_WIDTH-1:0] accel_databus,
  output logic                accel_busrdwr,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [2:0]          layer_idx
);

  state_t              state_q, state_d;
  logic [2:0]          layer_q, layer_d;
  logic [3:0]          num_q, num_d;
  logic [2:0]          beat_q, beat_d;
  logic [15:0]         cnt_q, cnt_d, cnt_inc;
  logic [PE_WIDTH-1:0] nout_q, nout_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [1:0]          err_q, err_d;
  logic                bad_start_q, bad_start_d;
  logic [2:0]          rd_field;
  logic [PE_WIDTH-1:0] rd_data;
  logic                rd_ok;
  logic                num_ok;

  layer_desc_table #(.MAX_LAYERS(MAX_LAYERS)) u_table (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_we),
    .wr_layer (cfg_addr[5:3]),
    .wr_field (cfg_addr[2:0]),
    .wdata    (cfg_wdata),
    .rd_layer (layer_q),
    .rd_field (rd_field),
    .rd_data  (rd_data),
    .rd_ok    (rd_ok)
  );

  assign num_ok  = (num_layers != 4'd0) && (int'(num_layers) <= MAX_LAYERS);
  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      num_q       <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      nout_q      <= '0;
      wdog_q      <= '0;
      err_q       <= ERR_NONE;
      bad_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      num_q       <= num_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      nout_q      <= nout_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      bad_start_q <= bad_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    num_d         = num_q;
    beat_d        = beat_q;
    cnt_d         = cnt_q;
    nout_d        = nout_q;
    wdog_d        = wdog_q;
    err_d         = err_q;
    bad_start_d   = 1'b0;
    rd_field      = FLD_NOUT;
    accel_enable  = 1'b0;
    accel_busrdwr = 1'b0;
    accel_databus = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_ok) begin
            err_d   = ERR_NONE;
            layer_d = '0;
            num_d   = num_layers;
            state_d = S_CHECK;
          end else begin
            err_d       = ERR_DESC;
            bad_start_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (!rd_ok) begin
          err_d   = ERR_DESC;
          state_d = S_FINISH;
        end else begin
          state_d = S_ENABLE;
        end
      end
      S_ENABLE: begin
        accel_enable = 1'b1;
        beat_d       = '0;
        state_d      = S_CFG;
      end
      S_CFG: begin
        rd_field      = beat_q;
        accel_busrdwr = 1'b1;
        accel_databus = rd_data;
        if (beat_q == FLD_NOUT) begin
          // n_out is latched so mid-run table writes only apply next pass
          nout_d  = rd_data;
          cnt_d   = '0;
          wdog_d  = '1;
          state_d = S_RUN;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      S_RUN: begin
        if (neuron_done) begin
          cnt_d  = cnt_inc;
          wdog_d = '1;
          if (cnt_inc == nout_q) begin
            state_d = S_NEXT;
          end
        end else if (wdog_q == '0) begin
          err_d   = ERR_WDOG;
          state_d = S_FINISH;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      S_NEXT: begin
        if ({1'b0, layer_q} == num_q - 4'd1) begin
          state_d = S_FINISH;
        end else begin
          layer_d = layer_q + 3'd1;
          state_d = S_CHECK;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH) || bad_start_q;
  assign err       = err_q;
  assign layer_idx = layer_q;

endmodule
